rr_mux_sel: RTL and testbench
=============================

RR_MUX_SEL -- requirements
Module: rr_mux_sel

Interface
REQ-001 Parameter: Tpd, default 1, propagation delay in time units applied to every registered output.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-channel request; bit i = data source d<i> of the downstream 4:1 mux wants service.
REQ-005 Port: ack  input  1  downstream has consumed the currently selected channel this cycle.
REQ-006 Port: s0  output  1  mux select LSB (selected channel index bit 0).
REQ-007 Port: s1  output  1  mux select MSB (selected channel index bit 1).
REQ-008 Port: valid  output  1  s1:s0 addresses a granted channel; mux output z is meaningful.
REQ-009 Port: gnt  output  4  one-hot grant, gnt[{s1,s0}] = 1 when valid, 4'b0000 otherwise.
REQ-010 Port: gnt_cnt  output  8  total grants issued since reset, saturating.

Function
REQ-011 Internal round-robin pointer ptr (2 bits) = search start index; priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 Two states: IDLE (valid=0) and BUSY (valid=1).
REQ-013 IDLE, req==0: remain IDLE; s1:s0, ptr, gnt_cnt unchanged.
REQ-014 IDLE, req!=0: next edge -> BUSY; s1:s0 = first set req bit in priority order; gnt_cnt +1. Latency req-to-valid: one clock.
REQ-015 BUSY, ack=0: s1:s0, gnt, valid held stable, even if the granted req bit drops (grant is sticky until ack).
REQ-016 BUSY, ack=1: ptr <= {s1,s0}+1 mod 4 (3 wraps to 0); winner for this edge chosen by REQ-011 with the updated ptr.
REQ-017 BUSY, ack=1, req!=0 (sampled same edge): stay BUSY, load new winner, gnt_cnt +1; back-to-back grants, no idle bubble.
REQ-018 BUSY, ack=1, req==0: -> IDLE; valid and gnt drop next edge; s1:s0 retain last value.
REQ-019 Requester just acked is eligible again only after the other three set requesters in priority order (fairness; no starvation with continuous requests).
REQ-020 ack in IDLE ignored: no state, ptr, or counter change.
REQ-021 gnt_cnt saturates at 8'hFF; further grants leave it at 8'hFF.
REQ-022 All outputs registered; no combinational path from req/ack to any output.
REQ-023 gnt always exactly one-hot or zero; never more than one bit set.

Reset
REQ-024 rst_n low asynchronously forces: state IDLE, ptr 0, s0 0, s1 0, valid 0, gnt 4'b0000, gnt_cnt 8'h00, without waiting for clk.
REQ-025 Reset asserted mid-BUSY abandons the grant immediately; ack at or after the reset release edge is treated per IDLE rules.
REQ-026 First active edge after rst_n rises follows REQ-013/REQ-014 with ptr 0.

Verification
REQ-027 Reset then req=4'b1010, ack=0 -> after 1 edge valid=1, s1:s0=01, gnt=0010, gnt_cnt=1; held for 5 cycles with no ack.
REQ-028 BUSY on ch1, req=4'b1010 held, ack=1 for one cycle -> next edge s1:s0=11, gnt=1000, valid stays 1, gnt_cnt=2; ack again -> s1:s0=01 (wrap via 0).
REQ-029 req=4'b1111 and ack=1 continuously -> s1:s0 sequence 00,01,10,11,00 on consecutive edges; valid never drops.
REQ-030 BUSY on ch2, req dropped to 0, ack=0 for 3 cycles -> grant held on ch2; then ack=1 -> next edge valid=0, gnt=0000, s1:s0=10.
REQ-031 BUSY on ch3, rst_n pulsed low between edges -> valid=0, gnt=0000, s1:s0=00, gnt_cnt=0 before the next rising edge.
REQ-032 300 back-to-back grants -> gnt_cnt reaches 8'hFF and remains 8'hFF; ack pulses in IDLE change nothing.

Source files
------------

// File: rtl/rr_mux_sel.sv
// Round-robin select generator for a downstream 4:1 mux.
// Sticky grant until ack, with a rotating search pointer.
module rr_mux_sel #(
   parameter int Tpd = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       ack,
   output logic       s0,
   output logic       s1,
   output logic       valid,
   output logic [3:0] gnt,
   output logic [7:0] gnt_cnt
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   // Tpd only carries meaning for timing-annotated models.
   if (Tpd < 0) begin : g_tpd_neg
   end

   logic [0:0] state, state_n;
   logic [1:0] ptr, ptr_n;
   logic [1:0] sel, sel_n;
   logic [3:0] gnt_n;
   logic [7:0] cnt_n;
   logic       cnt_inc;
   logic [1:0] nxt_ptr;

   // First set request at or after start index p, wrapping mod 4.
   function automatic logic [1:0] pick(
      input logic [3:0] r,
      input logic [1:0] p
   );
      logic [1:0] idx;
      pick = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   assign nxt_ptr = sel + 2'd1;

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sel_n   = sel;
      cnt_inc = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_n = BUSY;
               sel_n   = pick(req, ptr);
               cnt_inc = 1'b1;
            end
         end
         BUSY: begin
            if (ack) begin
               ptr_n = nxt_ptr;
               if (|req) begin
                  sel_n   = pick(req, nxt_ptr);
                  cnt_inc = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      gnt_n = (state_n == BUSY) ? (4'b0001 << sel_n) : 4'b0000;
      cnt_n = (cnt_inc && gnt_cnt != 8'hFF) ? gnt_cnt + 8'd1 : gnt_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         sel     <= 2'd0;
         gnt     <= 4'b0000;
         gnt_cnt <= 8'h00;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         sel     <= sel_n;
         gnt     <= gnt_n;
         gnt_cnt <= cnt_n;
      end
   end

   assign valid = (state == BUSY);
   assign s0    = sel[0];
   assign s1    = sel[1];

endmodule

// File: tb/tb_rr_mux_sel.sv
// Directed scoreboard bench for rr_mux_sel.
// Expected {valid,s1,s0,gnt,gnt_cnt} queued per step, checked after the edge.
module tb_rr_mux_sel;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       ack;
   logic       s0, s1, valid;
   logic [3:0] gnt;
   logic [7:0] gnt_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      logic [14:0] exp;
   } sb_t;

   sb_t sb[$];

   rr_mux_sel #(.Tpd(1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .ack(ack),
      .s0(s0),
      .s1(s1),
      .valid(valid),
      .gnt(gnt),
      .gnt_cnt(gnt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] mk(
      input logic       v,
      input logic [1:0] sel,
      input logic [7:0] cnt
   );
      logic [3:0] g;
      g = v ? (4'b0001 << sel) : 4'b0000;
      return {v, sel, g, cnt};
   endfunction

   function automatic logic [14:0] obs();
      return {valid, s1, s0, gnt, gnt_cnt};
   endfunction

   task automatic check_now(input string tag, input logic [14:0] exp);
      logic [14:0] o;
      o = obs();
      tests++;
      assert (o === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, o, exp);
      end
   endtask

   task automatic step(
      input string       tag,
      input logic [3:0]  r,
      input logic        a,
      input logic [14:0] exp
   );
      sb_t e;
      req = r;
      ack = a;
      sb.push_back('{tag, exp});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_now(e.tag, e.exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] sel;
      logic [7:0] cnt;
      rst_n = 1'b0;
      req   = 4'b0000;
      ack   = 1'b0;
      #3;
      check_now("reset", mk(0, 2'd0, 8'h00));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      step("first_grant", 4'b1010, 1'b0, mk(1, 2'd1, 8'd1));
      for (int i = 0; i < 5; i++)
         step("hold_noack", 4'b1010, 1'b0, mk(1, 2'd1, 8'd1));

      step("ack_to_ch3", 4'b1010, 1'b1, mk(1, 2'd3, 8'd2));
      step("wrap_to_ch1", 4'b1010, 1'b1, mk(1, 2'd1, 8'd3));

      step("rr_a", 4'b1111, 1'b1, mk(1, 2'd2, 8'd4));
      step("rr_b", 4'b1111, 1'b1, mk(1, 2'd3, 8'd5));
      step("rr_0", 4'b1111, 1'b1, mk(1, 2'd0, 8'd6));
      step("rr_1", 4'b1111, 1'b1, mk(1, 2'd1, 8'd7));
      step("rr_2", 4'b1111, 1'b1, mk(1, 2'd2, 8'd8));
      step("rr_3", 4'b1111, 1'b1, mk(1, 2'd3, 8'd9));
      step("rr_0w", 4'b1111, 1'b1, mk(1, 2'd0, 8'd10));

      step("to_ch2", 4'b0100, 1'b1, mk(1, 2'd2, 8'd11));
      for (int i = 0; i < 3; i++)
         step("sticky_ch2", 4'b0000, 1'b0, mk(1, 2'd2, 8'd11));
      step("drop_idle", 4'b0000, 1'b1, mk(0, 2'd2, 8'd11));
      step("idle_ack", 4'b0000, 1'b1, mk(0, 2'd2, 8'd11));

      step("to_ch3", 4'b1000, 1'b0, mk(1, 2'd3, 8'd12));
      #3;
      req   = 4'b0000;
      ack   = 1'b1;
      rst_n = 1'b0;
      #1;
      check_now("async_rst", mk(0, 2'd0, 8'h00));
      #1;
      rst_n = 1'b1;
      step("post_rst_idle", 4'b0000, 1'b1, mk(0, 2'd0, 8'h00));
      step("post_rst_ptr0", 4'b1111, 1'b0, mk(1, 2'd0, 8'd1));

      sel = 2'd0;
      cnt = 8'd1;
      for (int i = 0; i < 300; i++) begin
         sel = sel + 2'd1;
         cnt = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
         step("b2b", 4'b1111, 1'b1, mk(1, sel, cnt));
      end
      step("sat_idle", 4'b0000, 1'b1, mk(0, sel, cnt));
      for (int i = 0; i < 3; i++)
         step("sat_idle_ack", 4'b0000, 1'b1, mk(0, sel, 8'hFF));
      step("sat_grant", 4'b0010, 1'b0, mk(1, 2'd1, 8'hFF));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
